// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after start, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin read arbiter merging NUM_SRC FIFO read ports into one registered stream.
// Define READ_ARB_BURST_EN to hold a grant for up to BURST_LEN pops (default: one pop per grant).
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int IW         = idx_w(NUM_SRC)
) (
  input  logic                          read_clk,
  input  logic                          read_rst,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_inc,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IW-1:0]                 out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  if (NUM_SRC < 2 || NUM_SRC > 16 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_read_arbiter: NUM_SRC must be 2..16 and BURST_LEN >= 1");
  end

  arb_state_e    state, state_nxt;
  logic [IW-1:0] gnt, last, start;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          gnt_empty, pop, limit_hit, release_g, load;

  assign start = (last == IW'(NUM_SRC - 1)) ? '0 : last + 1'b1;

  rr_pick #(.N(NUM_SRC)) u_pick (
    .req   (~src_empty),
    .start (start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign gnt_empty = src_empty[gnt];
  assign pop       = (state == GRANT) && !gnt_empty && (!out_valid || out_ready);
  assign release_g = (state == GRANT) && (gnt_empty || (pop && limit_hit));
  // Release re-arbitrates on the same edge so a handover costs no cycle.
  assign load      = ((state == IDLE) || release_g) && pick_found;

`ifdef READ_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] cnt;

  assign limit_hit = (cnt == CW'(BURST_LEN - 1));

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst)  cnt <= '0;
    else if (load) cnt <= '0;
    else if (pop)  cnt <= cnt + 1'b1;
  end
`else
  assign limit_hit = 1'b1;
`endif

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found)               state_nxt = GRANT;
      GRANT:   if (release_g && !pick_found) state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_inc      = '0;
    src_inc[gnt] = pop;
    busy         = (state == GRANT);
  end

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      gnt  <= '0;
      last <= IW'(NUM_SRC - 1);
    end else if (load) begin
      gnt  <= pick_idx;
      last <= pick_idx;
    end
  end

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= src_data[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
      out_src   <= gnt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: FIFO read-side models plus a queue-based round-robin scoreboard.
module tb_fifo_read_arbiter;
  localparam int NUM_SRC = 4;
  localparam int DW      = 8;
  localparam int BL      = 4;
  localparam int IW      = 2;
  localparam int DEPTH   = 64;
`ifdef READ_ARB_BURST_EN
  localparam int LIMIT = BL;
`else
  localparam int LIMIT = 1;
`endif

  logic                   read_clk = 1'b0;
  logic                   read_rst = 1'b1;
  logic [NUM_SRC-1:0]     src_empty;
  logic [NUM_SRC*DW-1:0]  src_data;
  logic [NUM_SRC-1:0]     src_inc;
  logic [DW-1:0]          out_data;
  logic [IW-1:0]          out_src;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic                   busy;

  int             wr [NUM_SRC];
  int             rd [NUM_SRC];
  logic [DW-1:0]  mem [NUM_SRC][DEPTH];
  logic [DW-1:0]  sq [NUM_SRC][$];
  int             expq[$];
  int             obsq[$];
  int             model_last = NUM_SRC - 1;
  int             checks = 0;
  int             failures = 0;
  logic           bad_pop = 1'b0;

  fifo_read_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .read_clk  (read_clk),
    .read_rst  (read_rst),
    .src_empty (src_empty),
    .src_data  (src_data),
    .src_inc   (src_inc),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 read_clk = ~read_clk;

  // Registered-empty FIFO read sides: a pop shows in empty/data after the edge.
  always_comb begin
    src_empty = '1;
    src_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_empty[i]           = (wr[i] == rd[i]);
      src_data[i*DW +: DW]   = mem[i][rd[i] % DEPTH];
    end
  end

  always @(posedge read_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (read_rst) rd[i] <= wr[i];
      else if (src_inc[i]) begin
        if (wr[i] == rd[i]) bad_pop <= 1'b1;
        rd[i] <= rd[i] + 1;
      end
    end
  end

  task automatic push_word(input int i, input logic [DW-1:0] d);
    mem[i][wr[i] % DEPTH] = d;
    wr[i] = wr[i] + 1;
    sq[i].push_back(d);
  endtask

  function automatic int rd_total();
    int s = 0;
    for (int i = 0; i < NUM_SRC; i++) s += rd[i];
    return s;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NUM_SRC; i++) if (wr[i] != rd[i]) return 0;
    return 1;
  endfunction

  // Reference: round-robin over non-empty sources, up to LIMIT words per turn.
  function automatic void model_sched();
    int idx, n;
    bit found;
    idx = 0;
    while (1) begin
      found = 0;
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (model_last + k) % NUM_SRC;
        if (sq[idx].size() > 0) begin found = 1; break; end
      end
      if (!found) break;
      n = 0;
      while (n < LIMIT && sq[idx].size() > 0) begin
        expq.push_back(idx * 256 + int'(sq[idx].pop_front()));
        n++;
      end
      model_last = idx;
    end
  endfunction

  task automatic do_reset();
    read_rst = 1'b1;
    out_ready = 1'b1;
    @(posedge read_clk); @(posedge read_clk); #1;
    read_rst = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) sq[i].delete();
    expq.delete();
    obsq.delete();
    model_last = NUM_SRC - 1;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for five cycles
  task automatic run_drain(input int mode, output int maxrun);
    int c, run, held_total;
    logic [DW-1:0] held;
    held = '0; held_total = 0; run = 0; maxrun = 0;
    obsq.delete();
    for (c = 0; c < 600; c++) begin
      @(posedge read_clk); #1;
      if (all_empty() && !out_valid && !busy) break;
      checks++;
      if ($countones(src_inc) > 1 || (out_valid && !out_ready && src_inc != '0) || bad_pop) begin
        failures++;
        $display("FAIL legality c=%0d src_inc=%b out_valid=%b out_ready=%b bad_pop=%b", c, src_inc, out_valid, out_ready, bad_pop);
      end
      run = out_valid ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (mode == 2 && c >= 4 && c < 8) begin
        checks++;
        if (out_data !== held || src_inc !== '0 || out_valid !== 1'b1 || rd_total() != held_total) begin
          failures++;
          $display("FAIL stall c=%0d data=%h want=%h src_inc=%b valid=%b pops=%0d want=%0d",
                   c, out_data, held, src_inc, out_valid, rd_total(), held_total);
        end
      end
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : !(c >= 3 && c < 8);
      if (mode == 2 && c == 3) begin held = out_data; held_total = rd_total(); end
      if (out_valid && out_ready) obsq.push_back(int'(out_src) * 256 + int'(out_data));
    end
    checks++;
    if (c >= 600) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d want=0", expq.size() - obsq.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || src_inc !== '0 || busy !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      failures++;
      $display("FAIL reset_values valid=%b inc=%b busy=%b data=%h src=%0d want 0", out_valid, src_inc, busy, out_data, out_src);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = DW'($urandom);
    push_word(2, d);
    @(posedge read_clk); #1;
    checks++;
    if (busy !== 1'b1 || src_inc !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant busy=%b src_inc=%b want busy=1 src_inc=0100", busy, src_inc);
    end
    @(posedge read_clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== d || out_src !== 2'd2 || src_inc !== '0) begin
      failures++;
      $display("FAIL single_word valid=%b data=%h src=%0d inc=%b want 1 %h 2 0000", out_valid, out_data, out_src, src_inc, d);
    end
    @(posedge read_clk); #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b valid=%b want 0 0", busy, out_valid);
    end
    sq[2].delete();
    model_last = 2;
  endtask

  task automatic test_order();
    int maxrun;
    do_reset();
    for (int w = 0; w < 2; w++) begin
      push_word(0, DW'($urandom)); push_word(1, DW'($urandom)); push_word(3, DW'($urandom));
    end
    model_sched();
    run_drain(0, maxrun);
    checks++;
    if (obsq.size() != expq.size()) begin
      failures++; $display("FAIL order_count got=%0d want=%0d", obsq.size(), expq.size());
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] != expq[i]) begin
        failures++; $display("FAIL order[%0d] got=%h want=%h", i, obsq[i], expq[i]);
      end
    end
`ifndef READ_ARB_BURST_EN
    checks++;
    if (maxrun != 6) begin
      failures++; $display("FAIL order_no_bubble run=%0d want=6", maxrun);
    end
`endif
    expq.delete();
  endtask

  task automatic test_burst_long();
    int maxrun;
    for (int w = 0; w < 6; w++) push_word(0, DW'($urandom));
    model_sched();
    run_drain(1, maxrun);
    checks++;
    if (obsq.size() != expq.size()) begin
      failures++; $display("FAIL long_count got=%0d want=%0d", obsq.size(), expq.size());
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] != expq[i]) begin
        failures++; $display("FAIL long[%0d] got=%h want=%h", i, obsq[i], expq[i]);
      end
    end
    expq.delete();
  endtask

  task automatic test_stall();
    int maxrun;
    for (int w = 0; w < 3; w++) push_word(1, DW'($urandom));
    for (int w = 0; w < 2; w++) push_word(2, DW'($urandom));
    model_sched();
    run_drain(2, maxrun);
    checks++;
    if (obsq.size() != expq.size()) begin
      failures++; $display("FAIL stall_count got=%0d want=%0d", obsq.size(), expq.size());
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] != expq[i]) begin
        failures++; $display("FAIL stall[%0d] got=%h want=%h", i, obsq[i], expq[i]);
      end
    end
    expq.delete();
  endtask

  task automatic test_wrap();
    int maxrun;
    push_word(3, DW'($urandom));
    model_sched();
    run_drain(0, maxrun);
    expq.delete();
    push_word(0, DW'($urandom)); push_word(3, DW'($urandom));
    model_sched();
    run_drain(0, maxrun);
    checks++;
    if (obsq.size() != 2 || (obsq[0] >> 8) != 0) begin
      failures++; $display("FAIL wrap_first n=%0d first_src=%0d want n=2 src=0", obsq.size(), obsq.size() ? obsq[0] >> 8 : -1);
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] != expq[i]) begin
        failures++; $display("FAIL wrap[%0d] got=%h want=%h", i, obsq[i], expq[i]);
      end
    end
    expq.delete();
  endtask

  task automatic test_random();
    int maxrun, n;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        n = $urandom_range(0, 5);
        if (i == r % NUM_SRC && n == 0) n = 1;
        for (int w = 0; w < n; w++) push_word(i, DW'($urandom));
      end
      model_sched();
      run_drain(1, maxrun);
      checks++;
      if (obsq.size() != expq.size()) begin
        failures++; $display("FAIL rand%0d_count got=%0d want=%0d", r, obsq.size(), expq.size());
      end
      for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
        checks++;
        if (obsq[i] != expq[i]) begin
          failures++; $display("FAIL rand%0d[%0d] got=%h want=%h", r, i, obsq[i], expq[i]);
        end
      end
      expq.delete();
    end
  endtask

  task automatic test_reset_mid();
    int maxrun;
    for (int w = 0; w < 3; w++) push_word(0, DW'($urandom));
    for (int w = 0; w < 2; w++) push_word(1, DW'($urandom));
    out_ready = 1'b1;
    repeat (3) @(posedge read_clk);
    #2 read_rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || src_inc !== '0 || busy !== 1'b0 || out_data !== '0 || out_src !== '0) begin
      failures++;
      $display("FAIL reset_mid valid=%b inc=%b busy=%b data=%h src=%0d want 0", out_valid, src_inc, busy, out_data, out_src);
    end
    do_reset();
    push_word(1, DW'($urandom)); push_word(3, DW'($urandom));
    model_sched();
    run_drain(0, maxrun);
    checks++;
    if (obsq.size() != 2 || (obsq[0] >> 8) != 1) begin
      failures++; $display("FAIL reset_mid_first n=%0d first_src=%0d want n=2 src=1", obsq.size(), obsq.size() ? obsq[0] >> 8 : -1);
    end
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] != expq[i]) begin
        failures++; $display("FAIL reset_mid[%0d] got=%h want=%h", i, obsq[i], expq[i]);
      end
    end
    expq.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_burst_long();
    test_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Read-side arbiter that drains NUM_SRC asynchronous FIFOs sharing one read clock domain and merges them into a single registered output stream. It watches each FIFO's read-empty flag, grants one non-empty FIFO at a time in round-robin order, and drives that FIFO's read-increment strobe. It captures the popped word into an output register with a valid/ready handshake. It sits between the read halves of the FIFOs and the single downstream consumer.

## Interface
- NUM_SRC, 4: number of FIFOs arbitrated, 2..16
- DATA_WIDTH, 8: FIFO word width
- BURST_LEN, 4: maximum consecutive pops per grant, ≥1; used only with burst mode
- read_clk  in  1  read-domain clock, shared by all FIFO read sides
- read_rst  in  1  reset, asynchronous, active-high
- src_empty  in  NUM_SRC  per-FIFO registered read_empty
- src_data  in  NUM_SRC*DATA_WIDTH  per-FIFO read data at the current read_addr; slice i is FIFO i
- src_inc  out  NUM_SRC  per-FIFO read_inc, at most one bit high
- out_data  out  DATA_WIDTH  registered output word
- out_src  out  max(1,$clog2(NUM_SRC))  index of the FIFO that supplied out_data
- out_valid  out  1  out_data/out_src hold a word
- out_ready  in  1  consumer accepts the word on an edge where out_valid=1
- busy  out  1  a grant is held (state GRANT)

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: index gnt owns the read port.
- Arbitration:
  - Search for the first i with src_empty[i]=0, starting at last+1 and wrapping modulo NUM_SRC.
  - last is the most recently granted index.
- IDLE→GRANT: on the edge where any src_empty bit is 0.
  - gnt ← the search result.
  - last ← gnt.
  - Burst count cnt ← 0.
- Pop condition: pop = (state==GRANT) && !src_empty[gnt] && (!out_valid || out_ready).
- src_inc[gnt] = pop, combinational. All other src_inc bits are 0.
- On a pop edge:
  - out_data ← src_data[gnt].
  - out_src ← gnt.
  - out_valid ← 1.
  - cnt ← cnt+1.
- Without a pop: out_valid clears on an edge where out_valid && out_ready. Otherwise out_data, out_src and out_valid hold.
- Release: grant is released on the edge where either of these holds:
  - src_empty[gnt]=1 is sampled in GRANT, or
  - a pop makes cnt reach the limit.
- Limit: BURST_LEN with burst mode, 1 without.
- On the release edge:
  - If another FIFO is non-empty, arbitration runs immediately. The state stays GRANT with the new gnt and cnt ← 0.
  - Otherwise the state goes to IDLE.
- The released index is eligible again only after every other non-empty index has been searched.
- Reset values:
  - state IDLE
  - last = NUM_SRC-1, so the first search starts at 0
  - gnt=0, cnt=0
  - out_valid=0, out_data=0, out_src=0
  - src_inc=0, busy=0

## Timing
- One word per cycle is sustained while the granted FIFO is non-empty and the consumer is ready.
- src_empty already reflects a pop on the following edge, so back-to-back pops need no bubble.
- Latency:
  - Grant is active one edge after src_empty falls (IDLE→GRANT).
  - The first pop occurs in the next cycle.
  - out_valid rises on the edge of the pop.
- Re-grant after release costs zero cycles. IDLE is entered only when all FIFOs are empty.
- Stall: while out_valid && !out_ready, src_inc stays 0 and the grant is held. cnt does not advance.
- Simultaneous: on an edge with both out_ready and a pop, the new word replaces the accepted one. out_valid stays 1.
- Reset mid-operation:
  - Any word in out_data is discarded.
  - src_inc drops asynchronously with the state.
  - The FIFOs are reset by the same read_rst.

## Configuration
- READ_ARB_BURST_EN defined: the grant is held for up to BURST_LEN pops. cnt is a register of width $clog2(BURST_LEN+1).
- READ_ARB_BURST_EN undefined: the limit is fixed at 1, so the arbiter rotates after every pop. The cnt register and the BURST_LEN dependency are removed.

## Structure
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, GRANT)
  - function idx_w(n) returning max(1,$clog2(n)), used for out_src, gnt and last
- One sub-module, rr_pick:
  - Combinational rotating priority encoder.
  - Inputs: request vector (~src_empty) and start index (last+1 mod NUM_SRC).
  - Outputs: found flag and index.
  - Instantiated once and used both in IDLE and on release.

## Test plan
- Reset with all FIFOs empty:
  - Response: out_valid=0, src_inc=0, busy=0.
  - Deassert read_rst, then FIFO 2 receives one word: gnt=2 one edge after its empty falls. Exactly one src_inc[2] pulse. out_data equals the word, out_src=2.
- FIFOs 0, 1 and 3 each hold 2 words, burst mode off, out_ready=1:
  - Output source order: 0,1,3,0,1,3.
  - Six consecutive valid cycles, no bubbles.
- Same preload of 2 words in FIFOs 0, 1 and 3, with READ_ARB_BURST_EN and BURST_LEN=4:
  - Order 0,0,1,1,3,3. Release is on empty, not on count.
  - Then preload FIFO 0 with 6 words: 4 pops, release, then 2 pops after re-grant.
- out_ready held low for 5 cycles with words pending:
  - src_inc=0 throughout, out_data stable.
  - Each FIFO's word count is unchanged.
  - After out_ready rises, nothing is lost or duplicated.
- Wrap-around: last=3 and FIFOs 0 and 3 non-empty → grant goes to 0 first.
- read_rst pulsed mid-burst: all outputs return to reset values immediately; after release the first grant searches from index 0.
